// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared encodings for the multi-cycle ARM sequencing FSM:
//                state codes, mux-select codes, op and funct codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // FSM state encoding (4-bit, FETCH at zero so reset lands on fetch)
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        VEXEC   = 4'd10,
        VWB     = 4'd11,
        UNKNOWN = 4'd12
    } state_t;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Writeback result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Instruction op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Funct[4:1] codes that look vector-like but are scalar/element ops
    localparam logic [3:0] F_MOV    = 4'b1110;
    localparam logic [3:0] F_MOVIDX = 4'b1101;

    // Register index of the program counter
    localparam logic [3:0] REG_PC = 4'd15;

    // A data-processing funct is a vector op when bit 4 is set, except MOV/MOVIDX
    function automatic logic is_vector_op(input logic [5:0] funct);
        return funct[4] && (funct[4:1] != F_MOV) && (funct[4:1] != F_MOVIDX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lane_counter
//  Description : Vector lane index for lane-serial ALU issue. Counts while
//                enabled, flags the last lane and wraps back to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_counter #(
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    output logic [LANE_W-1:0] o_lane,
    output logic              o_wrap
);

    logic [LANE_W-1:0] r_lane;

    // Lane index: advance once per enabled cycle, return to zero after the last lane
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane <= '0;
        end else if (i_en) begin
            if (o_wrap) begin
                r_lane <= '0;
            end else begin
                r_lane <= r_lane + 1'b1;
            end
        end
    end

    assign o_lane = r_lane;
    assign o_wrap = (r_lane == LANE_W'(LANES - 1));

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main sequencing FSM of the multi-cycle ARM core with vector
//                extension. Steps each instruction through fetch, decode,
//                execute, memory and writeback, issuing vector ops lane by
//                lane over the shared ALU. Drives strobes and selects only.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    input  logic              MemReady,
    output logic              IRWrite,
    output logic              NextPC,
    output logic              Branch,
    output logic              RegW,
    output logic              MemW,
    output logic              VecW,
    output logic              VecIdxW,
    output logic              LaneWE,
    output logic [LANE_W-1:0] LaneIdx,
    output logic              PCS,
    output logic              AdrSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic              ALUOp,
    output logic              Done,
    output logic              Illegal
);

    state_t            r_state;
    state_t            w_next;
    logic              r_illegal;
    logic [LANE_W-1:0] w_lane;
    logic              w_wrap;

    logic w_irwrite, w_nextpc, w_branch, w_regw, w_memw, w_vecw;
    logic w_vecidxw, w_lanewe, w_pcs, w_done;
    logic [LANE_W-1:0] w_laneidx;

    lane_counter #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_counter (
        .clk    (clk),
        .reset  (reset),
        .i_en   (r_state == VEXEC),
        .o_lane (w_lane),
        .o_wrap (w_wrap)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky illegal flag, raised as the FSM enters the absorbing UNKNOWN state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else if (w_next == UNKNOWN) begin
            r_illegal <= 1'b1;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        w_next    = r_state;
        w_irwrite = 1'b0;
        w_nextpc  = 1'b0;
        w_branch  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_vecw    = 1'b0;
        w_vecidxw = 1'b0;
        w_lanewe  = 1'b0;
        w_laneidx = '0;
        w_pcs     = 1'b0;
        w_done    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RM;
        ResultSrc = RES_ALUOUT;
        ALUOp     = 1'b0;

        case (r_state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                w_irwrite = MemReady;
                w_nextpc  = MemReady;
                if (MemReady) begin
                    w_next = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                case (Op)
                    OP_MEM:  w_next = MEMADR;
                    OP_BR:   w_next = BRANCH;
                    OP_UND:  w_next = UNKNOWN;
                    default: begin
                        if (is_vector_op(Funct)) begin
                            w_next = VEXEC;
                        end else if (Funct[5]) begin
                            w_next = EXECI;
                        end else begin
                            w_next = EXECR;
                        end
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB = SRCB_IMM;
                w_next  = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    w_next = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc = RES_RDATA;
                w_regw    = 1'b1;
                w_pcs     = (Rd == REG_PC);
                w_done    = 1'b1;
                w_next    = FETCH;
            end
            MEMWR: begin
                // Write strobe is held for the whole wait so memory sees a stable request
                AdrSrc = 1'b1;
                w_memw = 1'b1;
                if (MemReady) begin
                    w_done = 1'b1;
                    w_next = FETCH;
                end
            end
            EXECR: begin
                ALUOp   = 1'b1;
                ALUSrcB = SRCB_RM;
                w_next  = ALUWB;
            end
            EXECI: begin
                ALUOp   = 1'b1;
                ALUSrcB = SRCB_IMM;
                w_next  = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                w_done    = 1'b1;
                w_next    = FETCH;
                if (Funct[4:1] == F_MOVIDX) begin
                    w_vecidxw = 1'b1;
                end else begin
                    w_regw = 1'b1;
                    w_pcs  = (Rd == REG_PC);
                end
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                w_branch  = 1'b1;
                w_done    = 1'b1;
                w_next    = FETCH;
            end
            VEXEC: begin
                ALUOp     = 1'b1;
                ALUSrcB   = Funct[5] ? SRCB_IMM : SRCB_RM;
                w_lanewe  = 1'b1;
                w_laneidx = w_lane;
                if (w_wrap) begin
                    w_next = VWB;
                end
            end
            VWB: begin
                w_vecw = 1'b1;
                w_done = 1'b1;
                w_next = FETCH;
            end
            UNKNOWN: begin
                w_next = UNKNOWN;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is held, so nothing fires during reset
    assign IRWrite = w_irwrite & reset;
    assign NextPC  = w_nextpc  & reset;
    assign Branch  = w_branch  & reset;
    assign RegW    = w_regw    & reset;
    assign MemW    = w_memw    & reset;
    assign VecW    = w_vecw    & reset;
    assign VecIdxW = w_vecidxw & reset;
    assign LaneWE  = w_lanewe  & reset;
    assign PCS     = w_pcs     & reset;
    assign Done    = w_done    & reset;
    assign LaneIdx = w_laneidx;
    assign Illegal = r_illegal;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main sequencing FSM for the multi-cycle ARM core with the vector extension. It steps each instruction through fetch, decode, execute, memory and writeback, so one ALU and one unified memory port are shared across cycles. Vector ALU ops are issued lane by lane over the same ALU under a lane counter. It drives strobes and mux selects only; ALUControl and FlagW decode stay in the existing combinational decoder, keyed by ALUOp.

Parameters:
LANES, 4, number of vector lanes executed per vector op (power of 2, >=2)
LANE_W, 2, width of lane index, equals log2(LANES)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
Op  in  2  instruction op field
Funct  in  6  instruction funct field
Rd  in  4  destination register index
MemReady  in  1  memory handshake; access completes in a cycle where it is 1
IRWrite  out  1  instruction register load strobe
NextPC  out  1  PC+4 write strobe
Branch  out  1  branch state indicator; cond unit gates the PC write
RegW  out  1  scalar register-file write
MemW  out  1  data memory write
VecW  out  1  vector register-file write
VecIdxW  out  1  vector element write (MOVIDX)
LaneWE  out  1  vector temp-lane write strobe
LaneIdx  out  LANE_W  current lane index
PCS  out  1  writeback targets R15
AdrSrc  out  1  0=PC, 1=ALU result
ALUSrcA  out  1  0=Rn, 1=PC
ALUSrcB  out  2  00=Rm, 01=imm, 10=const 4
ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALU direct
ALUOp  out  1  1=decoder selects the op from Funct; 0=ADD
Done  out  1  one-cycle pulse on instruction retire
Illegal  out  1  sticky illegal-op flag

Behaviour:
- Moore FSM. Outputs are combinational from state, plus MemReady/Funct/Rd qualifiers where stated. Unlisted strobes are 0, unlisted selects are 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, VEXEC, VWB, UNKNOWN.
- Reset low: state=FETCH, lane=0, Illegal=0. While reset is low, all strobes (IRWrite, NextPC, Branch, RegW, MemW, VecW, VecIdxW, LaneWE, Done, PCS) are 0.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=NextPC=MemReady. Stay while MemReady=0, else go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state:
  - Op=01 -> MEMADR
  - Op=10 -> BRANCH
  - Op=11 -> UNKNOWN
  - Op=00, Funct[4]=1 and Funct[4:1] not in {1101,1110} -> VEXEC
  - Op=00, Funct[5]=1 -> EXECI
  - otherwise EXECR
- MEMADR: ALUSrcB=01. Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD: AdrSrc=1. Stay until MemReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegW=1, PCS=(Rd==15), Done=1. Next FETCH.
- MEMWR: AdrSrc=1, MemW=1, held every cycle while waiting. On MemReady=1: Done=1, next FETCH.
- EXECR: ALUOp=1, ALUSrcB=00. EXECI: ALUOp=1, ALUSrcB=01. Both go to ALUWB.
- ALUWB: ResultSrc=00, Done=1, next FETCH.
  - Funct[4:1]=1101 (MOVIDX): VecIdxW=1, RegW=0, PCS=0.
  - Otherwise: RegW=1, PCS=(Rd==15).
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1, Done=1. Next FETCH.
- VEXEC: ALUOp=1, ALUSrcB=Funct[5]?01:00, LaneWE=1, LaneIdx=lane. lane increments each cycle. At lane=LANES-1: lane wraps to 0 and next state is VWB. Occupancy is exactly LANES cycles.
- VWB: VecW=1, Done=1, next FETCH. lane is 0 on exit.
- UNKNOWN: Illegal=1, all strobes 0, absorbing. Only reset leaves it.
- LaneIdx=0 outside VEXEC.
- Latency with MemReady=1 (cycles FETCH to retire, inclusive):
  - data-proc: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - vector: LANES+3
- Each cycle MemReady=0 in FETCH/MEMRD/MEMWR adds one cycle.
- Reset asserted mid-instruction (including mid-VEXEC) aborts it; no partial VecW is issued.

Decomposition:
- Package ctrl_pkg: state encoding constants (4-bit, FETCH=0), ALUSrcB/ResultSrc select constants, op codes OP_DP=00, OP_MEM=01, OP_BR=10, funct codes F_MOV=1110, F_MOVIDX=1101.
- Optional sub-module lane_counter (LANE_W bits, enable, wrap flag). Next-state logic and output decode stay in multicycle_ctrl.

Test Plan:
- ADD reg (Op=00, Funct=001000, Rd=3), MemReady=1 -> states FETCH,DECODE,EXECR,ALUWB; RegW=1 only in cycle 4; Done pulses in cycle 4; PCS=0.
- LDR (Op=01, Funct=011001) with MemReady=0 for 2 cycles in MEMRD -> retire at cycle 7; RegW only in MEMWB; AdrSrc=1 in MEMRD.
- Vector add (Op=00, Funct=010000), LANES=4 -> LaneWE=1 with LaneIdx 0,1,2,3 on consecutive cycles, then VecW=1 once, Done at cycle 7.
- MOVIDX (Funct=111010) -> EXECI, ALUWB with VecIdxW=1, RegW=0. MOV with Rd=15 (Funct=111100) -> RegW=1, PCS=1.
- Op=11 -> UNKNOWN; Illegal stays 1 and all strobes 0 for 10+ cycles; reset low then high -> FETCH, Illegal=0.
- Reset asserted with LaneIdx=2 in VEXEC -> LaneIdx=0 and state FETCH immediately; VecW never asserted.
